// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence display path: scheduler state
// encoding, sequence length and the 7-segment value table indexed by idx.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sched_state_t;

  localparam int SEQ_LEN = 8;

  // Active-high segment patterns (gfedcba) for digits 0..7.
  localparam logic [7:0] SEQ_TABLE [SEQ_LEN] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07
  };

endpackage

// File: rtl/seq_tick_gen.sv
// Half-second prescaler: counts 0..HALF-1 while en is high and pulses tick
// on the terminal count; clr restarts the count from zero.
module seq_tick_gen #(
  parameter int HALF = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = en && (r_cnt == CW'(HALF - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_step_scheduler.sv
// Run/pause/stop sequencer issuing a wrapped table index and one-cycle step
// strobe. Define SEQ_SCHED_PINGPONG_EN for bounce-at-ends indexing.
module seq_step_scheduler
  import seq_pkg::*;
#(
  parameter int FPGA_F = 50_000_000,
  parameter int LEN    = SEQ_LEN,
  parameter int IW     = $clog2(LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          fast,
  input  logic          up,
  output logic [IW-1:0] idx,
  output logic          step,
  output logic          running,
  output logic [1:0]    o_dbg_state
);

  localparam int HALF = FPGA_F / 2;

  sched_state_t  r_state;
  sched_state_t  w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_idx_nxt;
  logic          r_step;
  logic          r_running;
  logic          r_phase;
  logic          w_en;
  logic          w_clr;
  logic          w_tick;
  logic          w_step_tick;

  // A stop sampled in RUN freezes the prescaler, so a coinciding tick is lost.
  assign w_en        = (r_state == RUN) && !stop;
  assign w_clr       = (r_state == IDLE) && start && !stop;
  assign w_step_tick = w_tick && (fast || r_phase);

  seq_tick_gen #(.HALF(HALF)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .en    (w_en),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start && !stop) w_state_nxt = RUN;
      RUN:     if (stop) w_state_nxt = PAUSE;
      PAUSE: begin
        if (stop)       w_state_nxt = IDLE;
        else if (start) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef SEQ_SCHED_PINGPONG_EN
  logic r_dir;
  logic w_eff_dir;
  logic w_dir_nxt;

  // Ends force the direction inward so idx can never leave 0..LEN-1.
  always_comb begin
    w_eff_dir = r_dir;
    if (r_idx == IW'(LEN - 1)) w_eff_dir = 1'b0;
    else if (r_idx == '0)      w_eff_dir = 1'b1;
    w_idx_nxt = w_eff_dir ? (r_idx + IW'(1)) : (r_idx - IW'(1));
    w_dir_nxt = w_eff_dir;
    if (w_idx_nxt == IW'(LEN - 1)) w_dir_nxt = 1'b0;
    else if (w_idx_nxt == '0)      w_dir_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir <= 1'b0;
    end else if (w_clr) begin
      r_dir <= up;
    end else if (w_step_tick) begin
      r_dir <= w_dir_nxt;
    end
  end
`else
  always_comb begin
    w_idx_nxt = '0;
    if (up) w_idx_nxt = (r_idx == IW'(LEN - 1)) ? '0 : (r_idx + IW'(1));
    else    w_idx_nxt = (r_idx == '0) ? IW'(LEN - 1) : (r_idx - IW'(1));
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_step    <= 1'b0;
      r_running <= 1'b0;
      r_phase   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
      r_step    <= w_step_tick;
      if ((r_state == PAUSE) && stop) r_idx <= '0;
      else if (w_step_tick)           r_idx <= w_idx_nxt;
      if (w_clr)                 r_phase <= 1'b0;
      else if (w_tick && !fast)  r_phase <= ~r_phase;
    end
  end

  assign idx         = r_idx;
  assign step        = r_step;
  assign running     = r_running;
  assign o_dbg_state = r_state;

endmodule
